// File: rtl/pulse_prescaler_if.sv
// Divisor request bus for pulse_prescaler: request/ready handshake plus
// the rejection flag and the divisor currently in use.
interface pulse_prescaler_if #(
  parameter int unsigned CNT_W = 16
);
  logic [CNT_W-1:0] div_in;
  logic             div_valid;
  logic             div_ready;
  logic             div_err;
  logic [CNT_W-1:0] div_active;

  modport master (
    output div_in,
    output div_valid,
    input  div_ready,
    input  div_err,
    input  div_active
  );

  modport slave (
    input  div_in,
    input  div_valid,
    output div_ready,
    output div_err,
    output div_active
  );
endinterface

// File: rtl/pulse_prescaler.sv
// Synchronises an asynchronous pulse, counts its rising edges on the system
// clock and emits a strobe or square wave every div_active edges.
module pulse_prescaler #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEF_DIV     = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             en,
  input  logic             mode,
  pulse_prescaler_if.slave div_bus,
  output logic             pulse_out
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEF_DIV);

  typedef enum logic [0:0] {
    ST_READY   = 1'b0,
    ST_PENDING = 1'b1
  } hs_state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       div_active_r;
  logic [CNT_W-1:0]       pend_r;
  logic                   div_ready_r;
  logic                   div_err_r;
  logic                   pulse_out_r;
  hs_state_t              state_r;
  hs_state_t              state_next_s;

  logic rise_s;
  logic count_s;
  logic wrap_s;
  logic fire_s;
  logic accept_s;
  logic reject_s;
  logic load_s;

  assign rise_s  = sync_r[SYNC_STAGES-1] & ~hist_r;
  assign count_s = rise_s & en;
  assign wrap_s  = count_s & (cnt_r == (div_active_r - CNT_ONE));
  assign fire_s  = count_s & (cnt_r == CNT_ZERO);

  // Synchroniser chain plus history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pulse_in};
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_READY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Handshake: a pending divisor is applied only at a wrap (or at once when
  // counting is disabled), so a period is never cut short.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    reject_s     = 1'b0;
    load_s       = 1'b0;
    case (state_r)
      ST_READY: begin
        if (div_bus.div_valid) begin
          if (div_bus.div_in == CNT_ZERO) begin
            reject_s = 1'b1;
          end else begin
            accept_s     = 1'b1;
            state_next_s = ST_PENDING;
          end
        end else begin
          state_next_s = ST_READY;
        end
      end
      ST_PENDING: begin
        if (!en || wrap_s) begin
          load_s       = 1'b1;
          state_next_s = ST_READY;
        end else begin
          state_next_s = ST_PENDING;
        end
      end
      default: begin
        state_next_s = ST_READY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (load_s) begin
      cnt_r <= CNT_ZERO;
    end else if (count_s) begin
      cnt_r <= wrap_s ? CNT_ZERO : (cnt_r + CNT_ONE);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_active_r <= DIV_RST;
      pend_r       <= CNT_ZERO;
      div_ready_r  <= 1'b1;
      div_err_r    <= 1'b0;
    end else begin
      div_active_r <= load_s ? pend_r : div_active_r;
      pend_r       <= accept_s ? div_bus.div_in : pend_r;
      div_ready_r  <= (state_next_s == ST_READY);
      div_err_r    <= reject_s;
    end
  end

  // Mode 0 strobes for one clk; mode 1 toggles, halving the fire rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_out_r <= 1'b0;
    end else if (mode) begin
      pulse_out_r <= pulse_out_r ^ fire_s;
    end else begin
      pulse_out_r <= fire_s;
    end
  end

  assign pulse_out          = pulse_out_r;
  assign div_bus.div_ready  = div_ready_r;
  assign div_bus.div_err    = div_err_r;
  assign div_bus.div_active = div_active_r;

endmodule

// File: tb/tb_pulse_prescaler.sv
// Directed bench for pulse_prescaler: strobe/square division, runtime reload,
// zero-divisor rejection, enable gating and reset mid-run.
module tb_pulse_prescaler;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic pulse_in;
  logic en;
  logic mode;
  logic pulse_out;
  logic exp_level;
  logic [8:0] fires;
  int n_cmp  = 0;
  int n_fail = 0;

  pulse_prescaler_if #(.CNT_W(CNT_W)) div_bus ();

  pulse_prescaler #(
    .CNT_W      (CNT_W),
    .DEF_DIV    (3),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .en       (en),
    .mode     (mode),
    .div_bus  (div_bus),
    .pulse_out(pulse_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One input pulse: 3 clks high, 3 clks low; pulse_out sampled after each clk.
  task automatic do_pulse(input string tag, input logic exp_fire);
    logic [5:0] trace;
    logic [5:0] exp;
    pulse_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) pulse_in = 1'b0;
      step();
      trace[k] = pulse_out;
    end
    if (mode) begin
      exp = {{4{exp_level ^ exp_fire}}, {2{exp_level}}};
      exp_level = exp_level ^ exp_fire;
    end else begin
      exp = exp_fire ? 6'b000100 : 6'b000000;
      exp_level = 1'b0;
    end
    check(tag, {26'd0, trace}, {26'd0, exp});
  endtask

  // Offer a divisor with en low so it is applied on the next clk.
  task automatic load_div(input logic [CNT_W-1:0] d);
    en = 1'b0;
    div_bus.div_in = d;
    div_bus.div_valid = 1'b1;
    step();
    div_bus.div_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    pulse_in = 1'b0;
    en = 1'b1;
    mode = 1'b0;
    exp_level = 1'b0;
    div_bus.div_in = 8'd0;
    div_bus.div_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_pulse_out", {31'd0, pulse_out}, 32'd0);
    check("rst_div_ready", {31'd0, div_bus.div_ready}, 32'd1);
    check("rst_div_err", {31'd0, div_bus.div_err}, 32'd0);
    check("rst_div_active", {24'd0, div_bus.div_active}, 32'd3);
    step();

    // Strobe divide by 3: fire on pulses 1, 4, 7.
    fires = 9'b001001001;
    for (int i = 0; i < 9; i++) do_pulse($sformatf("strobe_p%0d", i + 1), fires[i]);

    // Square output with divisor 2: toggles on pulses 1, 3, 5, 7.
    en = 1'b0;
    div_bus.div_in = 8'd2;
    div_bus.div_valid = 1'b1;
    step();
    div_bus.div_valid = 1'b0;
    check("accept_ready_low", {31'd0, div_bus.div_ready}, 32'd0);
    step();
    check("load_en0_active", {24'd0, div_bus.div_active}, 32'd2);
    check("load_en0_ready", {31'd0, div_bus.div_ready}, 32'd1);
    en = 1'b1;
    mode = 1'b1;
    fires = 9'b001010101;
    for (int i = 0; i < 8; i++) do_pulse($sformatf("square_p%0d", i + 1), fires[i]);

    // Runtime reload: divisor 4, offer 2 after pulse 2, applied at wrap on pulse 4.
    mode = 1'b0;
    load_div(8'd4);
    en = 1'b1;
    do_pulse("reload_p1", 1'b1);
    do_pulse("reload_p2", 1'b0);
    div_bus.div_in = 8'd2;
    div_bus.div_valid = 1'b1;
    step();
    div_bus.div_valid = 1'b0;
    check("reload_ready_low", {31'd0, div_bus.div_ready}, 32'd0);
    check("reload_active_hold", {24'd0, div_bus.div_active}, 32'd4);
    do_pulse("reload_p3", 1'b0);
    check("reload_active_p3", {24'd0, div_bus.div_active}, 32'd4);
    do_pulse("reload_p4", 1'b0);
    check("reload_active_p4", {24'd0, div_bus.div_active}, 32'd2);
    check("reload_ready_back", {31'd0, div_bus.div_ready}, 32'd1);
    do_pulse("reload_p5", 1'b1);
    do_pulse("reload_p6", 1'b0);
    do_pulse("reload_p7", 1'b1);

    // Zero divisor is rejected with a one-clk error flag.
    div_bus.div_in = 8'd0;
    div_bus.div_valid = 1'b1;
    step();
    div_bus.div_valid = 1'b0;
    check("zero_err_high", {31'd0, div_bus.div_err}, 32'd1);
    check("zero_ready", {31'd0, div_bus.div_ready}, 32'd1);
    check("zero_active", {24'd0, div_bus.div_active}, 32'd2);
    step();
    check("zero_err_low", {31'd0, div_bus.div_err}, 32'd0);

    // Enable gating: cnt held at 1 through 5 ignored pulses.
    en = 1'b0;
    for (int i = 0; i < 5; i++) do_pulse($sformatf("gated_p%0d", i + 1), 1'b0);
    en = 1'b1;
    do_pulse("resume_p1", 1'b0);
    do_pulse("resume_p2", 1'b1);

    // Reset mid-run with cnt = 2 and a pending divisor.
    load_div(8'd4);
    en = 1'b1;
    do_pulse("prerst_p1", 1'b1);
    do_pulse("prerst_p2", 1'b0);
    div_bus.div_in = 8'd5;
    div_bus.div_valid = 1'b1;
    step();
    div_bus.div_valid = 1'b0;
    check("prerst_ready_low", {31'd0, div_bus.div_ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_pulse_out", {31'd0, pulse_out}, 32'd0);
    check("midrst_div_ready", {31'd0, div_bus.div_ready}, 32'd1);
    check("midrst_div_err", {31'd0, div_bus.div_err}, 32'd0);
    check("midrst_div_active", {24'd0, div_bus.div_active}, 32'd3);
    do_pulse("postrst_p1", 1'b1);
    do_pulse("postrst_p2", 1'b0);
    do_pulse("postrst_p3", 1'b0);
    check("postrst_active_p3", {24'd0, div_bus.div_active}, 32'd3);
    do_pulse("postrst_p4", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_prescaler.md
# pulse_prescaler

Clock-domain pulse prescaler for the frequency counter front end. Synchronises an asynchronous pulse input, detects its rising edges and divides the edge rate by a divisor that is loadable at run time. It offers a one-cycle strobe output or a square-wave output. Unlike the fixed-divisor pulse divider, the whole block runs on the system clock; the input pulse is never used as a clock.

## Interface
Parameters:
- CNT_W, 16: width of the divisor and edge counter; legal divisors are 1..2^CNT_W-1.
- DEF_DIV, 2: divisor after reset; must be in 1..2^CNT_W-1.
- SYNC_STAGES, 2: synchroniser depth for pulse_in; minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- pulse_in  in  1  asynchronous pulse source; high and low phases each ≥ 2 clk periods.
- en  in  1  count enable; when low, detected edges are ignored.
- mode  in  1  0 = strobe output, 1 = square output.
- div_in  in  CNT_W  requested divisor.
- div_valid  in  1  divisor request valid.
- div_ready  out  1  block can accept a divisor.
- div_err  out  1  one-cycle flag: a zero divisor was offered.
- div_active  out  CNT_W  divisor currently in use.
- pulse_out  out  1  divided output, registered.

## Operation
- Synchroniser: a SYNC_STAGES-deep flop chain, plus one history flop.
  - edge = last stage & ~history.
- Counter cnt (CNT_W bits), reset value 0.
- fire = edge & en & (cnt == 0).
- On edge & en:
  - cnt wraps to 0 when cnt == div_active-1;
  - otherwise cnt increments.
- The first edge after reset always fires.
- pulse_out register:
  - mode 0: next = fire, giving a one-clk strobe;
  - mode 1: next = pulse_out ^ fire, giving a square wave of period 2·div_active input edges.
  - Switching mode mid-run applies from the next clk with no other side effect.
- en low: cnt holds, no fire; in mode 1 pulse_out holds its level, in mode 0 it is 0.
- Divisor handshake:
  - Transfer occurs when div_valid & div_ready.
  - div_in == 0: rejected, div_err = 1 for the next cycle, nothing stored, div_ready stays 1.
  - div_in ≠ 0: stored in the pending register, and div_ready goes 0.
- Applying a pending divisor (glitch-free, never mid-period):
  - If en = 1, it is loaded into div_active on the clk where cnt wraps to 0.
  - If en = 0, it is loaded on the next clk.
  - On load, cnt is forced to 0 and div_ready returns to 1 on the following cycle.
- Simultaneous accept and wrap: the value accepted in that cycle is not applied at that wrap; it waits for the next one.
- div_active = 1: every enabled edge fires (mode 0), or pulse_out toggles on every edge (mode 1).

## Timing
- Reset values:
  - cnt = 0, div_active = DEF_DIV, pending empty;
  - div_ready = 1, div_err = 0, pulse_out = 0;
  - synchroniser and history flops = 0.
- Latency: pulse_in rises before clk edge E1; pulse_out changes on edge E(SYNC_STAGES+1), which is E3 at the default depth.
- div_err is asserted exactly one cycle, on the clk after the rejected transfer.
- div_ready deasserts on the clk after an accepted transfer.
- Maximum input rate is fclk/4; faster inputs give undefined edge counts, with no lock-up.
- rst mid-operation:
  - every register returns to its reset value on the next clk;
  - a pending divisor is discarded;
  - rst dominates all other inputs.

## Test plan
- Strobe divide: DEF_DIV = 3, mode 0, en 1, 9 input pulses -> exactly 3 one-clk strobes, on pulses 1, 4 and 7, each 3 clks after the pulse_in rising edge.
- Square output: div 2, mode 1, 8 input pulses -> pulse_out toggles on pulses 1, 3, 5 and 7, giving a period of 4 input pulses.
- Runtime reload: div 4, offer div_in = 2 after pulse 2:
  - div_ready drops;
  - div_active stays 4 until the wrap at pulse 4, then becomes 2;
  - strobes fire on pulses 1, 5 and 7.
- Zero divisor: offer div_in = 0 -> div_err high for 1 clk, div_active unchanged, div_ready stays 1.
- Enable gating: en = 0 during 5 pulses -> no strobes and cnt frozen; re-enable -> counting resumes from the held cnt.
- Reset mid-run: assert rst with cnt = 2 and a pending divisor:
  - all outputs return to reset values and the pending divisor is dropped;
  - the first pulse after reset strobes.
